// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem requests and a
// two-entry {pc, instr} buffer presented to decode with valid/ready.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pcplus4,
  input  logic            id_ready
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] buf_pc    [2];
  logic [XLEN-1:0] buf_instr [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;
  logic            accept;
  logic            push;
  logic            pop;
  logic            full;

  assign full = (count == 2'd2);

  // Request issue and response routing; a redirect suppresses new
  // requests and turns an in-flight response into one to discard.
  always_comb begin
    state_nx       = state;
    imem_req_valid = 1'b0;
    accept         = 1'b0;
    push           = 1'b0;
    unique case (state)
      REQ: begin
        imem_req_valid = !full && !redirect_valid;
        accept         = imem_req_valid && imem_req_ready;
        if (accept) state_nx = WAIT;
      end
      WAIT: begin
        if (imem_resp_valid) begin
          push     = !redirect_valid;
          state_nx = REQ;
        end else if (redirect_valid) begin
          state_nx = DROP;
        end
      end
      DROP: begin
        if (imem_resp_valid) state_nx = REQ;
      end
      default: state_nx = REQ;
    endcase
    if (reset) begin
      imem_req_valid = 1'b0;
      accept         = 1'b0;
      push           = 1'b0;
    end
  end

  assign imem_req_addr = pc;
  assign id_valid      = !reset && (count != 2'd0);
  assign pop           = id_valid && id_ready && !redirect_valid;

  // Head of the buffer; forced to zero while reset is asserted.
  assign id_pc      = reset ? '0 : buf_pc[rd_ptr];
  assign id_instr   = reset ? '0 : buf_instr[rd_ptr];
  assign id_pcplus4 = reset ? '0 : buf_pc[rd_ptr] + XLEN'(4);

  // FSM state, fetch PC and the address of the outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= REQ;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= state_nx;
      if (redirect_valid) begin
        pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (accept) begin
        pc     <= pc + XLEN'(4);
        req_pc <= pc;
      end
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Buffer storage written at the tail on each accepted response.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else if (push) begin
      buf_pc[wr_ptr]    <= req_pc;
      buf_instr[wr_ptr] <= imem_resp_data;
    end
  end

endmodule
